// File: rtl/dc_pkg.sv
// dc_pkg: opcode and FU-class constants plus the decoded dispatch entry layout for dc_dispatch_queue
package dc_pkg;
  localparam logic [4:0] R_TYPE = 5'b01100;
  localparam logic [4:0] F_TYPE = 5'b10100;
  localparam logic [4:0] LOAD   = 5'b00000;
  localparam logic [4:0] FLOAD  = 5'b00001;
  localparam logic [4:0] S_TYPE = 5'b01000;
  localparam logic [4:0] FSTORE = 5'b01001;
  localparam logic [4:0] B_TYPE = 5'b11000;
  localparam logic [4:0] JAL    = 5'b11011;
  localparam logic [4:0] JALR   = 5'b11001;
  localparam logic [4:0] I_TYPE = 5'b00100;
  localparam logic [4:0] LUI    = 5'b01101;
  localparam logic [4:0] AUIPC  = 5'b00101;
  localparam logic [4:0] CSR    = 5'b11100;
  localparam logic [2:0] FU_ALU = 3'd0;
  localparam logic [2:0] FU_MUL = 3'd1;
  localparam logic [2:0] FU_FPU = 3'd3;
  localparam logic [2:0] FU_LDU = 3'd6;
  localparam logic [2:0] FU_STU = 3'd7;
  localparam int DC_PREG_W = 7;
  localparam int DC_ROB_W  = 3;
  localparam int DC_LSQ_W  = 2;
  typedef struct packed {
    logic [31:0]          pc;
    logic [31:0]          inst;
    logic [31:0]          imm;
    logic [4:0]           op;
    logic [2:0]           f3;
    logic [6:0]           f7;
    logic [DC_PREG_W-1:0] P_rs1;
    logic [DC_PREG_W-1:0] P_rs2;
    logic [DC_PREG_W-1:0] P_rd;
    logic [DC_ROB_W-1:0]  rob_idx;
    logic [DC_LSQ_W-1:0]  LQ_tail;
    logic [DC_LSQ_W-1:0]  SQ_tail;
    logic [2:0]           fu_sel;
    logic                 jump;
  } dc_entry_t;
  function automatic int dc_entry_w(int p, int r, int l);
    return 115 + 3 * p + r + 2 * l;
  endfunction
endpackage

// File: rtl/dc_decoder.sv
// dc_decoder: combinational field/immediate/FU-class/register-index decode of one instruction
module dc_decoder
  import dc_pkg::*;
(
  input  logic [31:0] inst,
  output logic [4:0]  op,
  output logic [2:0]  f3,
  output logic [6:0]  f7,
  output logic [31:0] imm,
  output logic [2:0]  fu_sel,
  output logic [5:0]  A_rs1,
  output logic [5:0]  A_rs2,
  output logic [5:0]  A_rd,
  output logic        allocate_rd,
  output logic        is_load,
  output logic        is_store
);
  logic unused_lo;
  assign unused_lo = ^inst[1:0];
  assign op = inst[6:2];
  assign f3 = inst[14:12];
  assign f7 = inst[31:25];
  assign is_load = op == LOAD || op == FLOAD;
  assign is_store = op == S_TYPE || op == FSTORE;
  assign A_rs1 = {op == F_TYPE, inst[19:15]};
  assign A_rs2 = {op == F_TYPE || op == FSTORE, inst[24:20]};
  assign A_rd = {op == F_TYPE || op == FLOAD, inst[11:7]};
  assign allocate_rd = !(is_store || op == B_TYPE) && A_rd != 6'd0;
  assign fu_sel = op == R_TYPE ? {2'b00, f7[0]} :
                  op == F_TYPE ? FU_FPU :
                  is_load      ? FU_LDU :
                  is_store     ? FU_STU : FU_ALU;
  // immediate extraction per instruction format
  always_comb begin
    imm = '0;
    case (op)
      B_TYPE:                    imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      JAL:                       imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      I_TYPE, LOAD, FLOAD, JALR: imm = {{20{inst[31]}}, inst[31:20]};
      S_TYPE, FSTORE:            imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      LUI, AUIPC:                imm = {inst[31:12], 12'd0};
      CSR:                       imm = {20'd0, inst[31:20]};
      default:                   imm = '0;
    endcase
  end
endmodule

// File: rtl/dc_dispatch_queue.sv
// dc_dispatch_queue: decode/dispatch stage with DEPTH-entry decoded FIFO to IS; EARLY_JAL_EN enables early JAL redirect
module dc_dispatch_queue
  import dc_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int PREG_W = DC_PREG_W,
  parameter int ROB_W  = DC_ROB_W,
  parameter int LSQ_W  = DC_LSQ_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [31:0]       in_pc,
  input  logic [31:0]       in_inst,
  input  logic              in_jump,
  output logic              in_ready,
  output logic [5:0]        A_rs1,
  output logic [5:0]        A_rs2,
  output logic [5:0]        A_rd,
  output logic              allocate_rd,
  input  logic [PREG_W-1:0] P_rs1,
  input  logic [PREG_W-1:0] P_rs2,
  input  logic [PREG_W-1:0] P_rd_new,
  input  logic [PREG_W-1:0] P_rd_old,
  input  logic              rob_ready,
  input  logic [ROB_W-1:0]  rob_idx,
  input  logic              ld_ready,
  input  logic              st_ready,
  input  logic [LSQ_W-1:0]  LQ_tail,
  input  logic [LSQ_W-1:0]  SQ_tail,
  output logic              dispatch_fire,
  output logic [2:0]        fu_sel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [dc_entry_w(PREG_W, ROB_W, LSQ_W)-1:0] out_entry,
  input  logic              flush,
  input  logic              stall,
  output logic              dc_redirect,
  output logic [31:0]       dc_redirect_pc
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  typedef struct packed {
    logic [31:0]       pc;
    logic [31:0]       inst;
    logic [31:0]       imm;
    logic [4:0]        op;
    logic [2:0]        f3;
    logic [6:0]        f7;
    logic [PREG_W-1:0] P_rs1;
    logic [PREG_W-1:0] P_rs2;
    logic [PREG_W-1:0] P_rd;
    logic [ROB_W-1:0]  rob_idx;
    logic [LSQ_W-1:0]  LQ_tail;
    logic [LSQ_W-1:0]  SQ_tail;
    logic [2:0]        fu_sel;
    logic              jump;
  } entry_t;
  entry_t mem [DEPTH];
  entry_t wr_entry;
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;
  logic [4:0] op;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [31:0] imm;
  logic is_load, is_store, deq, jump;
  logic unused_rd_old;
  assign unused_rd_old = ^P_rd_old;
  dc_decoder u_dec (
    .inst(in_inst), .op(op), .f3(f3), .f7(f7), .imm(imm), .fu_sel(fu_sel),
    .A_rs1(A_rs1), .A_rs2(A_rs2), .A_rd(A_rd), .allocate_rd(allocate_rd),
    .is_load(is_load), .is_store(is_store)
  );
`ifdef EARLY_JAL_EN
  assign jump = in_jump || op == JAL;
  assign dc_redirect = dispatch_fire && op == JAL && !in_jump;
  assign dc_redirect_pc = in_pc + imm;
`else
  assign jump = in_jump;
  assign dc_redirect = 1'b0;
  assign dc_redirect_pc = '0;
`endif
  assign in_ready = rob_ready && (!is_store || st_ready) && (!is_load || ld_ready) &&
                    count < CW'(DEPTH) && !flush && !stall;
  assign dispatch_fire = in_valid && in_ready;
  assign out_valid = count != '0 && !flush && !stall;
  assign deq = out_valid && out_ready;
  assign out_entry = mem[head];
  assign wr_entry = '{pc: in_pc, inst: in_inst, imm: imm, op: op, f3: f3, f7: f7,
                      P_rs1: P_rs1, P_rs2: P_rs2, P_rd: P_rd_new, rob_idx: rob_idx,
                      LQ_tail: LQ_tail, SQ_tail: SQ_tail, fu_sel: fu_sel, jump: jump};
  // pointer/count bookkeeping; flush empties the queue without touching storage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      if (dispatch_fire) tail <= tail + PW'(1);
      if (deq) head <= head + PW'(1);
      count <= count + CW'(dispatch_fire) - CW'(deq);
    end
  end
  // entry storage, written at tail on dispatch
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (dispatch_fire) begin
      mem[tail] <= wr_entry;
    end
  end
endmodule

// File: tb/tb_dc_dispatch_queue.sv
// tb_dc_dispatch_queue: scoreboard bench for dc_dispatch_queue (define EARLY_JAL_EN to check the redirect build)
module tb_dc_dispatch_queue;
  import dc_pkg::*;
  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_jump, in_ready, allocate_rd, rob_ready, ld_ready, st_ready;
  logic dispatch_fire, out_valid, out_ready, flush, stall, dc_redirect;
  logic [31:0] in_pc, in_inst, dc_redirect_pc;
  logic [5:0] A_rs1, A_rs2, A_rd;
  logic [6:0] P_rs1, P_rs2, P_rd_new, P_rd_old;
  logic [2:0] rob_idx, fu_sel;
  logic [1:0] LQ_tail, SQ_tail;
  logic [dc_entry_w(7, 3, 2)-1:0] out_entry;
  dc_entry_t oe;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [2:0]  rob;
    logic        jump;
  } exp_t;
  exp_t sb[$];
  exp_t e;
  int total = 0;
  int bad = 0;
  int mc;
  logic [31:0] pc;
  assign oe = out_entry;
  always #5 clk = ~clk;

  dc_dispatch_queue dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst),
    .in_jump(in_jump), .in_ready(in_ready), .A_rs1(A_rs1), .A_rs2(A_rs2), .A_rd(A_rd),
    .allocate_rd(allocate_rd), .P_rs1(P_rs1), .P_rs2(P_rs2), .P_rd_new(P_rd_new),
    .P_rd_old(P_rd_old), .rob_ready(rob_ready), .rob_idx(rob_idx), .ld_ready(ld_ready),
    .st_ready(st_ready), .LQ_tail(LQ_tail), .SQ_tail(SQ_tail), .dispatch_fire(dispatch_fire),
    .fu_sel(fu_sel), .out_valid(out_valid), .out_ready(out_ready), .out_entry(out_entry),
    .flush(flush), .stall(stall), .dc_redirect(dc_redirect), .dc_redirect_pc(dc_redirect_pc)
  );

  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [11:0] imm);
    return {imm, 5'd0, 3'b000, rd, 7'h13};
  endfunction
  function automatic logic [31:0] lw(input logic [4:0] rd, input logic [11:0] imm);
    return {imm, 5'd2, 3'b010, rd, 7'h03};
  endfunction
  function automatic logic [31:0] flw(input logic [4:0] rd, input logic [11:0] imm);
    return {imm, 5'd2, 3'b010, rd, 7'h07};
  endfunction
  function automatic logic [31:0] sw(input logic [4:0] rs2, input logic [11:0] imm);
    return {imm[11:5], rs2, 5'd2, 3'b010, imm[4:0], 7'h23};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1 && out_valid && out_ready) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_pop: dequeue pc=%h but no entry required", oe.pc);
      end else begin
        e = sb.pop_front();
        if ({oe.pc, oe.imm, oe.rob_idx, oe.jump} !== {e.pc, e.imm, e.rob, e.jump}) begin
          bad++;
          $display("FAIL sb_entry: got pc=%h imm=%h rob=%0d jump=%b, need pc=%h imm=%h rob=%0d jump=%b",
                   oe.pc, oe.imm, oe.rob_idx, oe.jump, e.pc, e.imm, e.rob, e.jump);
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b0;
    #12;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b need 0", out_valid); end
    total++; if (out_entry !== '0) begin bad++; $display("FAIL rst_out_entry: got %h need 0", out_entry); end
    total++; if (dc_redirect !== 1'b0) begin bad++; $display("FAIL rst_redirect: got %b need 0", dc_redirect); end
    @(negedge clk);
    rst = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_pc = 32'h40 + 32'(4 * i); in_inst = addi(5'(i + 1), 12'(i + 7));
      tick();
    end
    in_valid = 1'b0;
    @(negedge clk);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rst_pre_valid: got %b need 1", out_valid); end
    #2 rst = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_async_valid: got %b need 0", out_valid); end
    total++; if (out_entry !== '0) begin bad++; $display("FAIL rst_async_entry: got %h need 0", out_entry); end
    #3 rst = 1'b1;
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready: got %b need 1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_post_valid: got %b need 0", out_valid); end
    tick();
  endtask

  task automatic test_fill();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_pc = 32'h100 + 32'(4 * i); in_inst = addi(5'(i + 1), 12'(8 * i + 1));
      rob_idx = 3'(i);
      @(negedge clk);
      total++; if (dispatch_fire !== 1'b1) begin bad++; $display("FAIL fill_fire%0d: got %b need 1", i, dispatch_fire); end
      sb.push_back('{pc: in_pc, imm: 32'(8 * i + 1), rob: 3'(i), jump: 1'b0});
      tick();
    end
    in_pc = 32'h110; in_inst = addi(5'd5, 12'd33); rob_idx = 3'd4;
    @(negedge clk);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL fill_full_ready: got %b need 0", in_ready); end
    total++; if (dispatch_fire !== 1'b0) begin bad++; $display("FAIL fill_full_fire: got %b need 0", dispatch_fire); end
    total++; if (oe.pc !== 32'h100) begin bad++; $display("FAIL fill_head_pc: got %h need 00000100", oe.pc); end
    total++; if (oe.imm !== 32'd1) begin bad++; $display("FAIL fill_head_imm: got %h need 1", oe.imm); end
    tick();
  endtask

  task automatic test_wrap();
    logic exp_rdy;
    int k;
    mc = 4; pc = 32'h110; k = 4;
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'b1; in_pc = pc; in_inst = addi(5'(k), 12'(8 * k + 1)); rob_idx = 3'(k);
      exp_rdy = mc < 4;
      @(negedge clk);
      total++; if (in_ready !== exp_rdy) begin bad++; $display("FAIL wrap_ready%0d: got %b need %b", c, in_ready, exp_rdy); end
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL wrap_valid%0d: got %b need 1", c, out_valid); end
      if (exp_rdy) begin
        sb.push_back('{pc: pc, imm: 32'(8 * k + 1), rob: 3'(k), jump: 1'b0});
        pc += 4; k++;
      end
      mc = mc + int'(exp_rdy) - 1;
      tick();
    end
    in_valid = 1'b0;
    while (mc > 0) begin
      @(negedge clk);
      mc--;
      tick();
    end
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL wrap_drained: got %b need 0", out_valid); end
    total++; if (sb.size() !== 0) begin bad++; $display("FAIL wrap_sb_left: got %0d need 0", sb.size()); end
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; ld_ready = 1'b0; st_ready = 1'b1; rob_idx = 3'd1;
    in_valid = 1'b1; in_pc = 32'h300; in_inst = lw(5'd3, 12'd12);
    @(negedge clk);
    total++; if (dispatch_fire !== 1'b0) begin bad++; $display("FAIL bp_lw_fire: got %b need 0", dispatch_fire); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_lw_ready: got %b need 0", in_ready); end
    total++; if (fu_sel !== 3'd6) begin bad++; $display("FAIL bp_lw_fu: got %0d need 6", fu_sel); end
    tick();
    in_pc = 32'h304; in_inst = sw(5'd4, 12'd20); rob_idx = 3'd2;
    @(negedge clk);
    total++; if (dispatch_fire !== 1'b1) begin bad++; $display("FAIL bp_sw_fire: got %b need 1", dispatch_fire); end
    total++; if (allocate_rd !== 1'b0) begin bad++; $display("FAIL bp_sw_alloc: got %b need 0", allocate_rd); end
    total++; if (fu_sel !== 3'd7) begin bad++; $display("FAIL bp_sw_fu: got %0d need 7", fu_sel); end
    sb.push_back('{pc: 32'h304, imm: 32'd20, rob: 3'd2, jump: 1'b0});
    tick();
    ld_ready = 1'b1; in_pc = 32'h308; in_inst = flw(5'd2, 12'd8); rob_idx = 3'd3;
    @(negedge clk);
    total++; if (A_rd !== 6'h22) begin bad++; $display("FAIL bp_flw_rd: got %h need 22", A_rd); end
    total++; if (fu_sel !== 3'd6) begin bad++; $display("FAIL bp_flw_fu: got %0d need 6", fu_sel); end
    total++; if (dispatch_fire !== 1'b1) begin bad++; $display("FAIL bp_flw_fire: got %b need 1", dispatch_fire); end
    total++; if (allocate_rd !== 1'b1) begin bad++; $display("FAIL bp_flw_alloc: got %b need 1", allocate_rd); end
    sb.push_back('{pc: 32'h308, imm: 32'd8, rob: 3'd3, jump: 1'b0});
    tick();
    in_valid = 1'b0; out_ready = 1'b1;
    tick(); tick();
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drained: got %b need 0", out_valid); end
    tick();
  endtask

  task automatic test_flush_stall();
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_pc = 32'h400 + 32'(4 * i); in_inst = addi(5'd9, 12'(i + 50)); rob_idx = 3'(i);
      tick();
    end
    flush = 1'b1; in_pc = 32'h408; out_ready = 1'b1;
    @(negedge clk);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL fl_ready: got %b need 0", in_ready); end
    total++; if (dispatch_fire !== 1'b0) begin bad++; $display("FAIL fl_fire: got %b need 0", dispatch_fire); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL fl_valid: got %b need 0", out_valid); end
    tick();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL fl_after_valid: got %b need 0", out_valid); end
    tick();
    out_ready = 1'b0; in_valid = 1'b1; in_pc = 32'h500; in_inst = addi(5'd6, 12'd77); rob_idx = 3'd5;
    @(negedge clk);
    total++; if (dispatch_fire !== 1'b1) begin bad++; $display("FAIL st_pre_fire: got %b need 1", dispatch_fire); end
    sb.push_back('{pc: 32'h500, imm: 32'd77, rob: 3'd5, jump: 1'b0});
    tick();
    stall = 1'b1; out_ready = 1'b1; in_pc = 32'h504;
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL st_valid: got %b need 0", out_valid); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL st_ready: got %b need 0", in_ready); end
    tick();
    stall = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL st_held_valid: got %b need 1", out_valid); end
    tick();
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL st_drained: got %b need 0", out_valid); end
    tick();
  endtask

  task automatic test_jal();
    logic exp_jump;
`ifdef EARLY_JAL_EN
    exp_jump = 1'b1;
`else
    exp_jump = 1'b0;
`endif
    out_ready = 1'b0; in_valid = 1'b1; in_jump = 1'b0; in_pc = 32'h200;
    in_inst = 32'h0200_00EF; rob_idx = 3'd6;
    @(negedge clk);
    total++; if (dispatch_fire !== 1'b1) begin bad++; $display("FAIL jal_fire: got %b need 1", dispatch_fire); end
    total++; if (dc_redirect !== exp_jump) begin bad++; $display("FAIL jal_redirect: got %b need %b", dc_redirect, exp_jump); end
`ifdef EARLY_JAL_EN
    total++; if (dc_redirect_pc !== 32'h220) begin bad++; $display("FAIL jal_target: got %h need 00000220", dc_redirect_pc); end
`else
    total++; if (dc_redirect_pc !== 32'h0) begin bad++; $display("FAIL jal_target: got %h need 0", dc_redirect_pc); end
`endif
    sb.push_back('{pc: 32'h200, imm: 32'h20, rob: 3'd6, jump: exp_jump});
    tick();
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    total++; if (dc_redirect !== 1'b0) begin bad++; $display("FAIL jal_redirect_idle: got %b need 0", dc_redirect); end
    tick();
    @(negedge clk);
    total++; if (sb.size() !== 0) begin bad++; $display("FAIL jal_sb_left: got %0d need 0", sb.size()); end
    tick();
  endtask

  initial begin
    in_valid = 1'b0; in_pc = '0; in_inst = '0; in_jump = 1'b0;
    P_rs1 = 7'd1; P_rs2 = 7'd2; P_rd_new = 7'd40; P_rd_old = 7'd3;
    rob_ready = 1'b1; rob_idx = '0; ld_ready = 1'b1; st_ready = 1'b1;
    LQ_tail = 2'd1; SQ_tail = 2'd2; out_ready = 1'b0; flush = 1'b0; stall = 1'b0;
    test_reset();
    test_fill();
    test_wrap();
    test_backpressure();
    test_flush_stall();
    test_jal();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
